// File: rtl/c3lib_ckg_en_ctrl.sv
// c3lib_ckg_en_ctrl
// Enable controller for a downstream positive-edge clock gater. It keeps the
// gated clock running while the consumer is busy, a wake request is pending or
// debug forces it on. After activity stops it waits through a programmable
// idle hysteresis before gating. Restarting the clock holds clk_en high for
// WAKE_DLY cycles before the clock is treated as running and a wake is
// acknowledged.
//
// Ports
//   clk           free-running source clock (also drives the clock gater)
//   rst           synchronous active-high reset
//   busy          consumer needs its clock
//   wake_req      four-phase wake request from outside the gated domain
//   cfg_force_on  keep the clock running (debug / scan setup)
//   cfg_idle_cnt  extra idle cycles before gating, captured on IDLE entry
//   clk_en        registered enable to the gater
//   wake_ack      four-phase acknowledge, high while the gated clock runs
//   state         FSM state: OFF=0, WAKE=1, ON=2, IDLE=3
module c3lib_ckg_en_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              cfg_force_on,
  input  logic [IDLE_W-1:0] cfg_idle_cnt,
  output logic              clk_en,
  output logic              wake_ack,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  state_e            state_q,    state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]        wake_cnt_q, wake_cnt_d;
  logic              clk_en_q,   clk_en_d;
  logic              wake_ack_q, wake_ack_d;
  logic              act;

  assign act = busy | wake_req | cfg_force_on;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_ON: begin
        if (!act) begin
          state_d    = ST_IDLE;
          idle_cnt_d = cfg_idle_cnt;
        end
      end
      ST_IDLE: begin
        // Activity wins over expiry; the counter only moves while nonzero.
        if (act) begin
          state_d = ST_ON;
        end else if (idle_cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          idle_cnt_d = idle_cnt_q - IDLE_W'(1);
        end
      end
      ST_OFF: begin
        if (act) begin
          state_d    = ST_WAKE;
          wake_cnt_d = 4'(WAKE_DLY - 1);
        end
      end
      ST_WAKE: begin
        // Activity is ignored here so a wake always completes in WAKE_DLY cycles.
        if (wake_cnt_q == 4'd0) begin
          state_d = ST_ON;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_ON;
    endcase

    // The enable is a flop of the next state so it never glitches on a decode.
    clk_en_d = (state_d != ST_OFF);

    wake_ack_d = wake_ack_q;
    if (!wake_req) begin
      wake_ack_d = 1'b0;
    end else if ((state_q == ST_ON) || (state_q == ST_IDLE)) begin
      wake_ack_d = 1'b1;
    end
  end

  // Reset leaves the clock running so the gated domain can reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ON;
      idle_cnt_q <= '0;
      wake_cnt_q <= 4'd0;
      clk_en_q   <= 1'b1;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= clk_en_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  assign clk_en   = clk_en_q;
  assign wake_ack = wake_ack_q;
  assign state    = state_q;

endmodule

// File: tb/tb_c3lib_ckg_en_ctrl.sv
// Testbench for c3lib_ckg_en_ctrl: directed scenarios with explicit expected
// values, then randomized stimulus against a phase/remaining-cycles model.
module tb_c3lib_ckg_en_ctrl;
  localparam int IDLE_W   = 8;
  localparam int WAKE_DLY = 2;
  localparam int S_OFF = 0, S_WAKE = 1, S_ON = 2, S_IDLE = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic              wake_req;
  logic              cfg_force_on;
  logic [IDLE_W-1:0] cfg_idle_cnt;
  logic              clk_en;
  logic              wake_ack;
  logic [1:0]        state;

  always #5 clk = ~clk;

  c3lib_ckg_en_ctrl #(.IDLE_W(IDLE_W), .WAKE_DLY(WAKE_DLY)) dut (
    .clk          (clk),
    .rst          (rst),
    .busy         (busy),
    .wake_req     (wake_req),
    .cfg_force_on (cfg_force_on),
    .cfg_idle_cnt (cfg_idle_cnt),
    .clk_en       (clk_en),
    .wake_ack     (wake_ack),
    .state        (state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: current phase plus the number of cycles left in it.
  int m_st   = S_ON;
  int m_left = 0;
  bit m_en   = 1'b1;
  bit m_ack  = 1'b0;

  task automatic tick();
    bit act;
    int prev;
    act  = busy | wake_req | cfg_force_on;
    prev = m_st;
    if (rst) begin
      m_st = S_ON; m_left = 0; m_ack = 1'b0;
    end else begin
      case (m_st)
        S_ON:   if (!act) begin m_st = S_IDLE; m_left = int'(cfg_idle_cnt) + 1; end
        S_IDLE: if (act) m_st = S_ON;
                else begin m_left--; if (m_left == 0) m_st = S_OFF; end
        S_OFF:  if (act) begin m_st = S_WAKE; m_left = WAKE_DLY; end
        default: begin m_left--; if (m_left == 0) m_st = S_ON; end
      endcase
      if (!wake_req) m_ack = 1'b0;
      else if (prev == S_ON || prev == S_IDLE) m_ack = 1'b1;
    end
    m_en = (m_st != S_OFF);
    @(posedge clk);
    #1;
    check_val("model_state", 32'(state), 32'(m_st));
    check_val("model_clk_en", 32'(clk_en), 32'(m_en));
    check_val("model_wake_ack", 32'(wake_ack), 32'(m_ack));
    check_val("ack_while_off_or_wake", 32'(wake_ack && (state == 2'd0 || state == 2'd1)), 32'd0);
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0; wake_req = 1'b0; cfg_force_on = 1'b0; cfg_idle_cnt = 8'd3;
    @(negedge clk);
    tick();
    check_val("reset_state", 32'(state), S_ON);
    check_val("reset_clk_en", 32'(clk_en), 1);
    check_val("reset_wake_ack", 32'(wake_ack), 0);

    // Idle gating with cfg_idle_cnt = 3: four IDLE cycles, clk_en falls on edge 5.
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val("idle_gate_state", 32'(state), (i <= 4) ? S_IDLE : S_OFF);
      check_val("idle_gate_clk_en", 32'(clk_en), (i <= 4) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) tick();
    check_val("stays_off", 32'(state), S_OFF);
    check_val("stays_off_clk_en", 32'(clk_en), 0);

    // Wake handshake.
    wake_req = 1'b1;
    tick(); check_val("wake1_state", 32'(state), S_WAKE); check_val("wake1_clk_en", 32'(clk_en), 1);
    tick(); check_val("wake2_state", 32'(state), S_WAKE);
    tick(); check_val("wake_on_state", 32'(state), S_ON); check_val("wake_on_ack", 32'(wake_ack), 0);
    tick(); check_val("ack_rise", 32'(wake_ack), 1);
    wake_req = 1'b0;
    tick(); check_val("ack_clear", 32'(wake_ack), 0);
    for (int i = 0; i < 4; i++) tick();
    check_val("back_off", 32'(state), S_OFF);

    // Reset during WAKE and during OFF.
    wake_req = 1'b1;
    tick(); check_val("pre_rst_wake", 32'(state), S_WAKE);
    rst = 1'b1;
    tick();
    check_val("rst_wake_state", 32'(state), S_ON);
    check_val("rst_wake_clk_en", 32'(clk_en), 1);
    check_val("rst_wake_ack", 32'(wake_ack), 0);
    rst = 1'b0; wake_req = 1'b0; cfg_idle_cnt = 8'd0;
    tick(); check_val("zero_idle_state", 32'(state), S_IDLE);
    tick(); check_val("zero_idle_off", 32'(state), S_OFF);
    rst = 1'b1;
    tick();
    check_val("rst_off_state", 32'(state), S_ON);
    check_val("rst_off_clk_en", 32'(clk_en), 1);
    rst = 1'b0;
    tick(); tick();
    check_val("off_again", 32'(state), S_OFF);

    // Force on: wake, then stay in ON regardless of busy.
    cfg_force_on = 1'b1; cfg_idle_cnt = 8'd2;
    for (int i = 1; i <= 20; i++) begin
      busy = 1'($urandom_range(0, 1));
      tick();
      if (i >= 3) check_val("force_on_state", 32'(state), S_ON);
    end
    cfg_force_on = 1'b0; busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_val("force_release_state", 32'(state), (i <= 3) ? S_IDLE : S_OFF);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      busy         = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) wake_req = ~wake_req;
      cfg_force_on = ($urandom_range(0, 49) == 0);
      cfg_idle_cnt = IDLE_W'($urandom_range(0, 6));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c3lib_ckg_en_ctrl.md
C3LIB_CKG_EN_CTRL -- requirements
Module: c3lib_ckg_en_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8: width of the idle-hysteresis count.
REQ-002 Parameter WAKE_DLY, default 2, legal 1..15: number of cycles clk_en is held high before a wake is acknowledged.
REQ-003 clk  input  1  free-running source clock; the same clock fed to the downstream positive-edge clock gater; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 busy  input  1  consumer-side activity indication; high means the gated domain needs its clock.
REQ-006 wake_req  input  1  four-phase wake request from a requester outside the gated domain.
REQ-007 cfg_force_on  input  1  forces the clock on, for debug or scan setup.
REQ-008 cfg_idle_cnt  input  IDLE_W  number of extra idle cycles before the clock is gated; sampled on entry to IDLE.
REQ-009 clk_en  output  1  enable to the clock gater's clk_en pin.
REQ-010 wake_ack  output  1  four-phase acknowledge; high means the gated clock is running.
REQ-011 state  output  2  FSM state, encoded OFF=0, WAKE=1, ON=2, IDLE=3.

Function
REQ-012 The FSM SHALL have 4 states: OFF, WAKE, ON and IDLE. The block SHALL hold one IDLE_W-bit idle counter and one 4-bit wake counter.
REQ-013 Define act = busy | wake_req | cfg_force_on, sampled at each rising edge.
REQ-014 ON: clk_en = 1. If act = 0, the FSM moves to IDLE and loads the idle counter with cfg_idle_cnt. Otherwise it stays in ON.
REQ-015 IDLE: clk_en = 1.
- If act = 1, the FSM returns to ON; act has priority over expiry.
- Else, if the idle counter = 0, the FSM moves to OFF.
- Else, the idle counter decrements by 1.
- Net effect: IDLE lasts exactly cfg_idle_cnt+1 cycles when act stays 0.
REQ-016 OFF: clk_en = 0. If act = 1, the FSM moves to WAKE and loads the wake counter with WAKE_DLY-1.
REQ-017 WAKE: clk_en = 1.
- If the wake counter = 0, the FSM moves to ON.
- Otherwise the wake counter decrements by 1.
- act is ignored while in WAKE, so WAKE always lasts exactly WAKE_DLY cycles and is never aborted.
REQ-018 clk_en SHALL be driven directly from a dedicated flop, never from a state decode, so it is glitch-free. The flop's next value is (next_state != OFF).
REQ-019 clk_en SHALL change only on the rising edge of clk. The gater's low-phase latch therefore sees a stable enable.
REQ-020 wake_ack flop behaviour:
- Set on an edge where wake_req = 1 and state is ON or IDLE.
- Cleared on any edge where wake_req = 0.
- Otherwise it holds.
REQ-021 wake_ack SHALL never be high while state is OFF or WAKE, except in the single case where wake_req stays high through a transition to OFF. That case cannot occur, because wake_req = 1 forces act = 1.
REQ-022 If cfg_idle_cnt = 0, IDLE lasts one cycle.
REQ-023 If cfg_idle_cnt changes while in IDLE, it SHALL have no effect until the next entry to IDLE.
REQ-024 The idle counter SHALL NOT wrap: it is only decremented when nonzero.
REQ-025 If cfg_force_on = 1 in any state, the FSM SHALL never enter OFF. If the FSM is already in OFF, it SHALL wake through WAKE normally.
REQ-026 The latency from act rising (sampled while in OFF) to state = ON SHALL be WAKE_DLY+1 edges. The first edge enters WAKE and clk_en rises at that same edge.

Reset
REQ-027 While rst = 1 at an edge, the block SHALL load: state = ON, clk_en = 1, wake_ack = 0, idle counter = 0, wake counter = 0. The clock runs during reset so the gated domain can itself reset.
REQ-028 rst asserted in any state (including mid-WAKE or mid-IDLE) SHALL take effect at the next edge, overriding all other inputs.
REQ-029 After rst deasserts, normal evaluation SHALL begin at the first edge from the ON state.

Verification (IDLE_W = 8, WAKE_DLY = 2)
REQ-030 Idle gating: cfg_idle_cnt = 3, rst released, busy = wake_req = 0.
- Required: state ON -> IDLE for 4 cycles -> OFF.
- clk_en falls at the 5th edge after rst release and then stays 0.
REQ-031 Wake handshake: start in OFF, raise wake_req.
- Required: WAKE for 2 cycles, clk_en = 1 from the first edge, then ON.
- wake_ack rises 1 edge after ON.
- Dropping wake_req clears wake_ack at the next edge.
REQ-032 Hysteresis abort: cfg_idle_cnt = 5, busy pulses high for one cycle during the 3rd IDLE cycle.
- Required: state returns to ON and clk_en never drops.
- A fresh IDLE then lasts 6 cycles.
REQ-033 Zero idle count: cfg_idle_cnt = 0.
- Required: ON -> IDLE for 1 cycle -> OFF.
- busy rising during the WAKE cycles does not shorten or extend WAKE's 2 cycles.
REQ-034 Reset mid-operation: rst asserted during WAKE (wake counter = 1) and separately during OFF.
- Required: next edge gives state = ON, clk_en = 1, wake_ack = 0.
REQ-035 Force on: cfg_force_on = 1 in OFF.
- Required: OFF -> WAKE -> ON and the block stays in ON indefinitely, independent of busy.
- Clearing cfg_force_on then gives IDLE for cfg_idle_cnt+1 cycles.
